// File: rtl/ats21_pkg.sv
// ats21_pkg: shared types and constants for the ATS21 client-side command issuer.
//   ats21_op_e      instruction opcodes (instruction bits [31:29])
//   issuer_state_e  issuer FSM states, also exported on the issuer debug port
//   ATS21_HALF_W    width of the ATS21 ctrl bus
package ats21_pkg;

  localparam int ATS21_HALF_W = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } ats21_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_HI = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESP    = 3'd4
  } issuer_state_e;

  // A nop never reaches the bus; it is answered locally with an ack.
  function automatic logic is_nop(input logic [2:0] op);
    return op == OP_NOP;
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// ats21_cmd_fifo: synchronous instruction FIFO with show-ahead read data.
//   clk, reset  clock and synchronous active-high reset (flushes the FIFO)
//   push, wdata write one entry; ignored when full
//   pop         discard the head entry; ignored when empty
//   rdata       current head entry (valid whenever empty is low)
//   full, empty occupancy flags
//   count       number of entries held (0..DEPTH)
module ats21_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Full refuses a push even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of 2).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ats21_cmd_issuer: buffers 32-bit ATS21 instructions and serializes each one
// onto one ATS21 client port as a high half (with req) then a low half, samples
// the port's stat bit and returns one ack/nack response per instruction.
//   clk, reset        clock (shared with the ATS21) and sync active-high reset
//   cmd_valid/ready   instruction input handshake, cmd_data = instruction
//   req, ctrl         ATS21 request strobe and 16-bit ctrl bus
//   stat_in           this port's ATS21 stat bit (1 = ack)
//   rsp_valid         one-cycle response pulse with rsp_ack and rsp_opcode
//   busy              FSM active or FIFO holding entries
//   fifo_count        entries held in the FIFO
//   dbg_state         current FSM state (issuer_state_e encoding)
//
// Handshake: an instruction is accepted on every rising clk edge where both
// cmd_valid and cmd_ready are high; cmd_ready depends only on the FIFO count,
// and cmd_valid/cmd_data must be held stable until accepted. The response has no
// ready: rsp_valid is high for exactly one cycle and must be sampled then.
module ats21_cmd_issuer
  import ats21_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RESP_WAIT  = 1,
  parameter int CMD_W      = 32,
  parameter int HALF_W     = ATS21_HALF_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [CMD_W-1:0]              cmd_data,
  output logic                          req,
  output logic [HALF_W-1:0]             ctrl,
  input  logic                          stat_in,
  output logic                          rsp_valid,
  output logic                          rsp_ack,
  output logic [2:0]                    rsp_opcode,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);

  localparam int CNT_W = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_WAIT - 1);

  issuer_state_e    state_q;
  issuer_state_e    state_d;
  logic [CMD_W-1:0] hold_q;
  logic [CMD_W-1:0] fifo_rdata;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             ack_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [2:0]       head_op;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign head_op   = fifo_rdata[CMD_W-1 -: 3];
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state = state_q;

  ats21_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = is_nop(head_op) ? ST_RESP : ST_SEND_HI;
      end
      ST_SEND_HI: state_d = ST_SEND_LO;
      ST_SEND_LO: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_q == '0) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      wait_cnt_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            hold_q <= fifo_rdata;
            if (is_nop(head_op)) ack_q <= 1'b1;
          end
        end
        ST_SEND_LO: wait_cnt_q <= CNT_LOAD;
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - 1'b1;
          if (wait_cnt_q == '0) ack_q <= stat_in;
        end
        default: ;
      endcase
    end
  end

  // Bus and response outputs decode only registered state, so there is no
  // combinational path from cmd_* or stat_in.
  always_comb begin
    req        = 1'b0;
    ctrl       = '0;
    rsp_valid  = 1'b0;
    rsp_ack    = 1'b0;
    rsp_opcode = 3'b000;
    case (state_q)
      ST_SEND_HI: begin
        req  = 1'b1;
        ctrl = hold_q[CMD_W-1:HALF_W];
      end
      ST_SEND_LO: ctrl = hold_q[HALF_W-1:0];
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_ack    = ack_q;
        rsp_opcode = hold_q[CMD_W-1 -: 3];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
module tb_ats21_cmd_issuer;
  import ats21_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT signals ----------------
  logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
  logic [31:0] cmd_data_a = '0, cmd_data_b = '0;
  logic        cmd_ready_a, cmd_ready_b;
  logic        req_a, req_b;
  logic [15:0] ctrl_a, ctrl_b;
  logic        stat_a, stat_b;
  logic        rsp_valid_a, rsp_valid_b, rsp_ack_a, rsp_ack_b;
  logic [2:0]  rsp_opcode_a, rsp_opcode_b;
  logic        busy_a, busy_b;
  logic [2:0]  fifo_count_a, fifo_count_b;
  logic [2:0]  dbg_state_a, dbg_state_b;

  logic stat_drv   = 1'b0;
  logic model_mode = 1'b0;
  logic m_stat_a = 1'b0, m_stat_b = 1'b0;
  logic m_seen_a = 1'b0, m_seen_b = 1'b0, m_conf = 1'b0;

  assign stat_a = model_mode ? m_stat_a : stat_drv;
  assign stat_b = model_mode ? m_stat_b : 1'b0;

  ats21_cmd_issuer u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data_a), .req(req_a), .ctrl(ctrl_a), .stat_in(stat_a),
    .rsp_valid(rsp_valid_a), .rsp_ack(rsp_ack_a), .rsp_opcode(rsp_opcode_a),
    .busy(busy_a), .fifo_count(fifo_count_a), .dbg_state(dbg_state_a)
  );

  ats21_cmd_issuer u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data_b), .req(req_b), .ctrl(ctrl_b), .stat_in(stat_b),
    .rsp_valid(rsp_valid_b), .rsp_ack(rsp_ack_b), .rsp_opcode(rsp_opcode_b),
    .busy(busy_b), .fifo_count(fifo_count_b), .dbg_state(dbg_state_b)
  );

  // ---------------- ATS21 model ----------------
  // Two set-clock requests in the same cycle naming the same clock (high-half
  // bits [12:9] = instruction bits [28:25]) conflict and are both nacked.
  // The verdict is driven on stat two cycles after req, i.e. during the WAIT cycle.
  always @(posedge clk) begin
    m_seen_a <= req_a;
    m_seen_b <= req_b;
    m_conf   <= req_a && req_b && (ctrl_a[15:13] == OP_SET_CLK) &&
                (ctrl_b[15:13] == OP_SET_CLK) && (ctrl_a[12:9] == ctrl_b[12:9]);
    if (m_seen_a) m_stat_a <= !m_conf;
    if (m_seen_b) m_stat_b <= !m_conf;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [3:0]  rsp_a_q[$];
  logic [3:0]  rsp_b_q[$];
  int          req_cyc_q[$];
  logic [15:0] req_ctrl_q[$];
  logic [3:0]  exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid_a) rsp_a_q.push_back({rsp_ack_a, rsp_opcode_a});
      if (rsp_valid_b) rsp_b_q.push_back({rsp_ack_b, rsp_opcode_b});
      if (req_a) begin
        req_cyc_q.push_back(cyc);
        req_ctrl_q.push_back(ctrl_a);
      end
    end
  end

  task automatic clear_logs();
    rsp_a_q.delete();
    rsp_b_q.delete();
    req_cyc_q.delete();
    req_ctrl_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req_a); end
    n_checks++; if (ctrl_a !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0000", ctrl_a); end
    n_checks++; if (rsp_valid_a !== 1'b0 || rsp_ack_a !== 1'b0 || rsp_opcode_a !== 3'b000) begin
      n_fail++; $display("FAIL reset_rsp: got v=%b a=%b op=%b want 0 0 000", rsp_valid_a, rsp_ack_a, rsp_opcode_a); end
    n_checks++; if (fifo_count_a !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count_a); end
    n_checks++; if (cmd_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_busy: got ready=%b busy=%b want 1 0", cmd_ready_a, busy_a); end
    n_checks++; if (dbg_state_a !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state_a); end
    reset = 1'b0;
  endtask

  // One instruction through the bus; stat carries s only in the capture cycle.
  task automatic test_single(input logic [31:0] d, input logic s, input logic [2:0] eop);
    @(negedge clk);                       // cycle P: push
    cmd_valid_a = 1'b1; cmd_data_a = d; stat_drv = ~s;
    @(negedge clk);                       // P+1: pop (N)
    cmd_valid_a = 1'b0;
    n_checks++; if (req_a !== 1'b0 || fifo_count_a !== 3'd1) begin
      n_fail++; $display("FAIL single_pop: got req=%b count=%0d want 0 1", req_a, fifo_count_a); end
    @(negedge clk);                       // N+1: high half
    n_checks++; if (req_a !== 1'b1 || ctrl_a !== d[31:16]) begin
      n_fail++; $display("FAIL single_hi: got req=%b ctrl=%h want 1 %h", req_a, ctrl_a, d[31:16]); end
    @(negedge clk);                       // N+2: low half
    n_checks++; if (req_a !== 1'b0 || ctrl_a !== d[15:0]) begin
      n_fail++; $display("FAIL single_lo: got req=%b ctrl=%h want 0 %h", req_a, ctrl_a, d[15:0]); end
    @(negedge clk);                       // N+3: stat captured at end of cycle
    stat_drv = s;
    n_checks++; if (req_a !== 1'b0 || ctrl_a !== 16'h0000 || rsp_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL single_wait: got req=%b ctrl=%h rv=%b want 0 0000 0", req_a, ctrl_a, rsp_valid_a); end
    @(negedge clk);                       // N+4: response
    stat_drv = ~s;
    n_checks++; if (rsp_valid_a !== 1'b1 || rsp_ack_a !== s || rsp_opcode_a !== eop) begin
      n_fail++; $display("FAIL single_rsp: got v=%b a=%b op=%b want 1 %b %b", rsp_valid_a, rsp_ack_a, rsp_opcode_a, s, eop); end
    @(negedge clk);                       // N+5: back to idle
    n_checks++; if (rsp_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got rv=%b busy=%b want 0 0", rsp_valid_a, busy_a); end
    stat_drv = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] cmds[5];
    logic [3:0]  got;
    int          k;
    cmds[0] = 32'h2000_0001; cmds[1] = 32'h4000_0002; cmds[2] = 32'h6000_0003;
    cmds[3] = 32'hA000_0004; cmds[4] = 32'hC000_0005;
    clear_logs();
    stat_drv = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, cmds[i][31:29]});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (cmd_ready_a !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready_a); end
      cmd_valid_a = 1'b1; cmd_data_a = cmds[i];
    end
    // Four held plus one already popped: full. Keep offering an extra command
    // across the cycle where a pop occurs; it must still be refused.
    @(negedge clk);
    cmd_data_a = 32'hE000_00EE;
    n_checks++; if (fifo_count_a !== 3'd4 || cmd_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL b2b_full: got count=%0d ready=%b want 4 0", fifo_count_a, cmd_ready_a); end
    @(negedge clk);
    n_checks++; if (fifo_count_a !== 3'd4) begin n_fail++; $display("FAIL b2b_full2: got %0d want 4", fifo_count_a); end
    @(negedge clk);
    cmd_valid_a = 1'b0;
    n_checks++; if (fifo_count_a !== 3'd3) begin
      n_fail++; $display("FAIL b2b_pop_no_push: got count=%0d want 3", fifo_count_a); end
    k = 0;
    while (rsp_a_q.size() < 5 && k < 60) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    n_checks++; if (rsp_a_q.size() != 5) begin
      n_fail++; $display("FAIL b2b_rsp_count: got %0d want 5", rsp_a_q.size()); end
    while (rsp_a_q.size() > 0 && exp_q.size() > 0) begin
      got = rsp_a_q.pop_front();
      n_checks++; if (got !== exp_q[0]) begin
        n_fail++; $display("FAIL b2b_rsp_order: got %h want %h", got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    n_checks++; if (req_cyc_q.size() != 5) begin
      n_fail++; $display("FAIL b2b_req_count: got %0d want 5", req_cyc_q.size()); end
    for (int i = 0; i < req_cyc_q.size() && i < 5; i++) begin
      n_checks++; if (req_ctrl_q[i] !== cmds[i][31:16]) begin
        n_fail++; $display("FAIL b2b_req_hi_%0d: got %h want %h", i, req_ctrl_q[i], cmds[i][31:16]); end
      if (i > 0) begin
        n_checks++; if (req_cyc_q[i] - req_cyc_q[i-1] != 5) begin
          n_fail++; $display("FAIL b2b_spacing_%0d: got %0d want 5", i, req_cyc_q[i] - req_cyc_q[i-1]); end
      end
    end
    stat_drv = 1'b0;
  endtask

  task automatic test_nop();
    clear_logs();
    stat_drv = 1'b0;
    @(negedge clk);                       // P: push nop
    cmd_valid_a = 1'b1; cmd_data_a = 32'h0000_0000;
    @(negedge clk);                       // P+1: pop
    cmd_valid_a = 1'b0;
    n_checks++; if (rsp_valid_a !== 1'b0 || req_a !== 1'b0) begin
      n_fail++; $display("FAIL nop_pop: got rv=%b req=%b want 0 0", rsp_valid_a, req_a); end
    @(negedge clk);                       // P+2: response
    n_checks++; if (rsp_valid_a !== 1'b1 || rsp_ack_a !== 1'b1 || rsp_opcode_a !== 3'b000) begin
      n_fail++; $display("FAIL nop_rsp: got v=%b a=%b op=%b want 1 1 000", rsp_valid_a, rsp_ack_a, rsp_opcode_a); end
    n_checks++; if (ctrl_a !== 16'h0000) begin n_fail++; $display("FAIL nop_ctrl: got %h want 0000", ctrl_a); end
    repeat (3) @(negedge clk);
    n_checks++; if (req_cyc_q.size() != 0 || rsp_a_q.size() != 1) begin
      n_fail++; $display("FAIL nop_bus: got reqs=%0d rsps=%0d want 0 1", req_cyc_q.size(), rsp_a_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] c0;
    c0 = 32'h2A40_BEEF;
    stat_drv = 1'b1;
    @(negedge clk); cmd_valid_a = 1'b1; cmd_data_a = c0;               // P
    @(negedge clk); cmd_data_a = 32'h4000_1111;                         // P+1
    @(negedge clk); cmd_data_a = 32'h6000_2222;                         // P+2
    @(negedge clk);                                                     // P+3: SEND_LO
    cmd_valid_a = 1'b0;
    n_checks++; if (dbg_state_a !== ST_SEND_LO || fifo_count_a !== 3'd2 || ctrl_a !== c0[15:0]) begin
      n_fail++; $display("FAIL rst_mid_pre: got st=%0d count=%0d ctrl=%h want 2 2 %h",
                         dbg_state_a, fifo_count_a, ctrl_a, c0[15:0]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    n_checks++; if (req_a !== 1'b0 || ctrl_a !== 16'h0000 || fifo_count_a !== 3'd0 || rsp_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_post: got req=%b ctrl=%h count=%0d rv=%b want 0 0000 0 0",
                         req_a, ctrl_a, fifo_count_a, rsp_valid_a); end
    repeat (12) @(negedge clk);
    n_checks++; if (rsp_a_q.size() != 0 || req_cyc_q.size() != 0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got rsps=%0d reqs=%0d busy=%b want 0 0 0",
                         rsp_a_q.size(), req_cyc_q.size(), busy_a); end
    stat_drv = 1'b0;
  endtask

  task automatic test_two_clients(input logic [31:0] da, input logic [31:0] db, input logic exp_ack);
    int k;
    clear_logs();
    model_mode = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b1; cmd_data_a = da;
    cmd_valid_b = 1'b1; cmd_data_b = db;
    @(negedge clk);
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    k = 0;
    while ((rsp_a_q.size() < 1 || rsp_b_q.size() < 1) && k < 30) begin @(negedge clk); k++; end
    n_checks++; if (rsp_a_q.size() != 1 || rsp_b_q.size() != 1) begin
      n_fail++; $display("FAIL two_rsp_count: got a=%0d b=%0d want 1 1", rsp_a_q.size(), rsp_b_q.size()); end
    if (rsp_a_q.size() > 0 && rsp_b_q.size() > 0) begin
      n_checks++; if (rsp_a_q[0] !== {exp_ack, 3'b001} || rsp_b_q[0] !== {exp_ack, 3'b001}) begin
        n_fail++; $display("FAIL two_rsp_ack: got a=%h b=%h want %h", rsp_a_q[0], rsp_b_q[0], {exp_ack, 3'b001}); end
    end
    repeat (3) @(negedge clk);
    model_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(32'h2A40_1234, 1'b1, 3'b001);
    test_single(32'hA301_0064, 1'b0, 3'b101);
    test_back_to_back();
    test_nop();
    test_reset_mid();
    test_two_clients(32'h2A40_1234, 32'h2A40_5678, 1'b0);
    test_two_clients(32'h2A40_1234, 32'h2C40_5678, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
